// File: rtl/iob_regfile_mp.sv
// Multi-port register file: prioritised byte-strobed write ports, async read ports, clear sweep.
// Optional write-first read forwarding is enabled by defining IOB_REGFILE_MP_BYPASS_EN.
module iob_regfile_mp #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32,
  parameter int W_PORTS = 2,
  parameter int R_PORTS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [W_PORTS-1:0]          w_valid,
  input  logic [W_PORTS*ADDR_W-1:0]   w_addr,
  input  logic [W_PORTS*DATA_W-1:0]   w_data,
  input  logic [W_PORTS*DATA_W/8-1:0] w_strb,
  output logic [W_PORTS-1:0]          w_ready,
  input  logic [R_PORTS*ADDR_W-1:0]   r_addr,
  output logic [R_PORTS*DATA_W-1:0]   r_data,
  input  logic                        clr_req,
  output logic                        busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                busy_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                win_s;

  function automatic logic [DATA_W-1:0] strb_mask(input logic [NB-1:0] strb);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

  // Fixed-priority arbitration: lowest-index requester wins each address.
  always_comb begin
    w_ready = '0;
    win_s   = 1'b0;
    if (!rst && (state_q == ST_IDLE) && !clr_req) begin
      for (int p = 0; p < W_PORTS; p++) begin
        win_s = w_valid[p];
        for (int q = 0; q < W_PORTS; q++) begin
          if ((q < p) && w_valid[q] &&
              (w_addr[q*ADDR_W +: ADDR_W] == w_addr[p*ADDR_W +: ADDR_W])) begin
            win_s = 1'b0;
          end else begin
            win_s = win_s;
          end
        end
        w_ready[p] = win_s;
      end
    end else begin
      w_ready = '0;
    end
  end

  // Next array contents: accepted byte-merged writes, or the sweep's zeroing.
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < W_PORTS; p++) begin
      if (w_ready[p]) begin
        mem_d[w_addr[p*ADDR_W +: ADDR_W]] =
          (mem_d[w_addr[p*ADDR_W +: ADDR_W]] & ~strb_mask(w_strb[p*NB +: NB])) |
          (w_data[p*DATA_W +: DATA_W] & strb_mask(w_strb[p*NB +: NB]));
      end else begin
        mem_d = mem_d;
      end
    end
    if (state_q == ST_CLEAR) begin
      mem_d[clr_cnt_q] = '0;
    end else begin
      mem_d = mem_d;
    end
  end

  // Read ports; forwarding reads the post-edge view so winners and the cleared entry show through.
  always_comb begin
    r_data = '0;
    for (int k = 0; k < R_PORTS; k++) begin
`ifdef IOB_REGFILE_MP_BYPASS_EN
      r_data[k*DATA_W +: DATA_W] = mem_d[r_addr[k*ADDR_W +: ADDR_W]];
`else
      r_data[k*DATA_W +: DATA_W] = mem_q[r_addr[k*ADDR_W +: ADDR_W]];
`endif
    end
  end

  // Storage, clear-sweep FSM and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      case (state_q)
        ST_IDLE: begin
          if (clr_req) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
          end else begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
          end
        end
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == LAST_IDX) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          clr_cnt_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_iob_regfile_mp.sv
// Directed self-checking bench for iob_regfile_mp (default 2x2 ports, 4 x 32-bit entries).
module tb_iob_regfile_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  w_valid;
  logic [3:0]  w_addr;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic [1:0]  w_ready;
  logic [3:0]  r_addr;
  logic [63:0] r_data;
  logic        clr_req;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] old_val [4];

  iob_regfile_mp #(.ADDR_W(2), .DATA_W(32), .W_PORTS(2), .R_PORTS(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .w_valid (w_valid),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .w_strb  (w_strb),
    .w_ready (w_ready),
    .r_addr  (r_addr),
    .r_data  (r_data),
    .clr_req (clr_req),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    w_valid = 2'b11;
    w_addr  = {2'd1, 2'd0};
    w_data  = 64'h0;
    w_strb  = 8'hFF;
    r_addr  = {2'd1, 2'd0};
    clr_req = 1'b0;
    #2;
    // T1 reset
    check("rst_ready", {30'd0, w_ready}, 32'd0);
    tick();
    rst     = 1'b0;
    w_valid = 2'b00;
    #1;
    check("rst_rd0", r_data[31:0], 32'h0);
    check("rst_rd1", r_data[63:32], 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // T2 dual write, distinct addresses
    w_valid = 2'b11;
    w_addr  = {2'd2, 2'd1};
    w_data  = {32'h12345678, 32'hAAAA5555};
    w_strb  = 8'hFF;
    #1;
    check("dual_ready", {30'd0, w_ready}, 32'd3);
    tick();
    w_valid = 2'b00;
    r_addr  = {2'd2, 2'd1};
    #1;
    check("dual_rd_a1", r_data[31:0], 32'hAAAA5555);
    check("dual_rd_a2", r_data[63:32], 32'h12345678);

    // T3 same-address conflict, port 1 stalls and retries
    w_valid = 2'b11;
    w_addr  = {2'd3, 2'd3};
    w_data  = {32'h00000022, 32'h00000011};
    r_addr  = {2'd3, 2'd3};
    #1;
    check("conf_ready1", {30'd0, w_ready}, 32'd1);
    tick();
    w_valid = 2'b10;
    #1;
    check("conf_ready2", {30'd0, w_ready}, 32'd2);
`ifdef IOB_REGFILE_MP_BYPASS_EN
    check("conf_rd_mid", r_data[31:0], 32'h00000022);
`else
    check("conf_rd_mid", r_data[31:0], 32'h00000011);
`endif
    tick();
    w_valid = 2'b00;
    #1;
    check("conf_rd_end", r_data[31:0], 32'h00000022);

    // T4 byte strobes
    w_valid = 2'b01;
    w_addr  = {2'd0, 2'd0};
    w_data  = {32'h0, 32'hFFFFFFFF};
    w_strb  = 8'h0F;
    tick();
    w_data  = {32'h0, 32'h000000AB};
    w_strb  = 8'h01;
    r_addr  = {2'd0, 2'd0};
    #1;
    check("strb_ready", {30'd0, w_ready}, 32'd1);
`ifdef IOB_REGFILE_MP_BYPASS_EN
    check("strb_rd_mid", r_data[31:0], 32'hFFFFFFAB);
`else
    check("strb_rd_mid", r_data[31:0], 32'hFFFFFFFF);
`endif
    tick();
    w_valid = 2'b00;
    #1;
    check("strb_rd", r_data[31:0], 32'hFFFFFFAB);

    // T6 same-cycle read of the address being written
    w_valid = 2'b01;
    w_addr  = {2'd0, 2'd2};
    w_data  = {32'h0, 32'h0000CAFE};
    w_strb  = 8'h0F;
    r_addr  = {2'd2, 2'd0};
    #1;
`ifdef IOB_REGFILE_MP_BYPASS_EN
    check("byp_rd", r_data[63:32], 32'h0000CAFE);
`else
    check("byp_rd", r_data[63:32], 32'h12345678);
`endif
    tick();
    w_valid = 2'b00;
    #1;
    check("byp_rd_after", r_data[63:32], 32'h0000CAFE);

    // T5 clear sweep over a fully populated array
    old_val[0] = 32'hFFFFFFAB;
    old_val[1] = 32'hAAAA5555;
    old_val[2] = 32'h0000CAFE;
    old_val[3] = 32'h00000022;
    clr_req = 1'b1;
    w_valid = 2'b11;
    w_addr  = {2'd1, 2'd0};
    w_data  = {32'h99999999, 32'h88888888};
    w_strb  = 8'hFF;
    #1;
    check("clr_req_ready", {30'd0, w_ready}, 32'd0);
    check("clr_req_busy", {31'd0, busy}, 32'd0);
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_addr = {2'd0, 2'(i)};
      #1;
      check($sformatf("sweep_busy%0d", i), {31'd0, busy}, 32'd1);
      check($sformatf("sweep_ready%0d", i), {30'd0, w_ready}, 32'd0);
`ifdef IOB_REGFILE_MP_BYPASS_EN
      check($sformatf("sweep_rd%0d", i), r_data[31:0], 32'h0);
`else
      check($sformatf("sweep_rd%0d", i), r_data[31:0], old_val[i]);
`endif
      tick();
    end
    w_valid = 2'b00;
    r_addr  = {2'd1, 2'd0};
    #1;
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_rd0", r_data[31:0], 32'h0);
    check("post_rd1", r_data[63:32], 32'h0);
    r_addr = {2'd3, 2'd2};
    #1;
    check("post_rd2", r_data[31:0], 32'h0);
    check("post_rd3", r_data[63:32], 32'h0);

    // Reset two cycles into a sweep
    w_valid = 2'b01;
    w_addr  = {2'd0, 2'd3};
    w_data  = {32'h0, 32'h00000077};
    w_strb  = 8'h0F;
    tick();
    w_valid = 2'b00;
    r_addr  = {2'd3, 2'd3};
    #1;
    check("pre_abort_rd3", r_data[31:0], 32'h00000077);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst     = 1'b1;
    w_valid = 2'b01;
    #1;
    check("abort_rst_ready", {30'd0, w_ready}, 32'd0);
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    rst     = 1'b0;
    w_valid = 2'b00;
    #1;
    check("abort_rd3", r_data[31:0], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
